// File: rtl/mux_tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pkg
// Description : Shared constants, mode enum and tree-geometry helpers for the
//               pipelined channel-select mux tree.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_tree_pkg;

    localparam int c_DEFAULT_W = 8;
    localparam int c_DEFAULT_N = 8;

    typedef enum logic {
        MODE_MANUAL = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    // Ceiling log2; exact for the power-of-two channel counts used here.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Word offset of tree level k inside a heap-packed store of 2N-1 words:
    // level 0 holds the N inputs, level k holds N>>k candidates.
    function automatic int tree_offset(input int n, input int k);
        return 2 * n - 2 * (n >> k);
    endfunction

endpackage : mux_tree_pkg
`default_nettype wire

// File: rtl/mux2_stage.sv
`default_nettype none
// ============================================================================
// Module      : mux2_stage
// Description : One registered level of the mux tree: COUNT 2:1 muxes steered
//               by one bit of the beat's channel tag, with valid/tag carried.
// Revision    : 1.0 - initial release
// ============================================================================
module mux2_stage
    import mux_tree_pkg::*;
#(
    parameter int W       = c_DEFAULT_W,
    parameter int COUNT   = 1,
    parameter int TAG_W   = 1,
    parameter int SEL_BIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_valid,
    input  logic [TAG_W-1:0]     i_tag,
    input  logic [2*COUNT*W-1:0] i_data,
    output logic                 o_valid,
    output logic [TAG_W-1:0]     o_tag,
    output logic [COUNT*W-1:0]   o_data
);

    logic [COUNT*W-1:0] w_next;
    logic [COUNT*W-1:0] r_data;
    logic [TAG_W-1:0]   r_tag;
    logic               r_valid;

    // Candidate k at this level covers the input pair (2k, 2k+1).
    generate
        for (genvar k = 0; k < COUNT; k++) begin : g_mux
            assign w_next[k*W +: W] = i_tag[SEL_BIT] ? i_data[(2*k+1)*W +: W]
                                                     : i_data[(2*k)*W +: W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_tag   <= '0;
            r_data  <= '0;
        end else if (i_en) begin
            r_valid <= i_valid;
            r_tag   <= i_tag;
            r_data  <= w_next;
        end
    end

    assign o_valid = r_valid;
    assign o_tag   = r_tag;
    assign o_data  = r_data;

endmodule : mux2_stage
`default_nettype wire

// File: rtl/mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_tree_pipe
// Description : N:1 channel selector built as a log2(N)-deep tree of
//               registered 2:1 levels with valid/ready flow control.
//               Define MUX_TREE_PIPE_SCAN_EN to build the auto-scan counter.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_tree_pipe
    import mux_tree_pkg::*;
#(
    parameter  int W = c_DEFAULT_W,
    parameter  int N = c_DEFAULT_N,
    localparam int L = log2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N*W-1:0] in_data,
    input  logic [L-1:0]   sel,
    input  logic           scan_en,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [W-1:0]   out_data,
    output logic [L-1:0]   out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int c_TOTAL = 2 * N - 1;

    logic [c_TOTAL*W-1:0] w_tree;
    logic [L:0]           w_valid;
    logic [L:0][L-1:0]    w_tag;
    logic                 w_adv;
    logic [L-1:0]         w_tag_in;
    logic [L-1:0]         w_scan_idx;
    mode_e                w_mode;

    // One enable moves the whole pipe; a stalled head freezes every level.
    assign w_adv    = out_ready | ~out_valid;
    assign in_ready = w_adv;

`ifdef MUX_TREE_PIPE_SCAN_EN
    logic [L-1:0] r_scan_cnt;

    assign w_mode     = scan_en ? MODE_SCAN : MODE_MANUAL;
    assign w_scan_idx = r_scan_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt <= '0;
        end else if (in_valid && w_adv && (w_mode == MODE_SCAN)) begin
            r_scan_cnt <= r_scan_cnt + L'(1);
        end
    end
`else
    // Port kept for interface compatibility; its value never selects scan.
    assign w_mode     = mode_e'(scan_en & 1'b0);
    assign w_scan_idx = '0;
`endif

    assign w_tag_in = (w_mode == MODE_SCAN) ? w_scan_idx : sel;

    assign w_tree[N*W-1:0] = in_data;
    assign w_valid[0]      = in_valid;
    assign w_tag[0]        = w_tag_in;

    generate
        for (genvar j = 0; j < L; j++) begin : g_level
            localparam int c_CNT     = N >> (j + 1);
            localparam int c_IN_LSB  = tree_offset(N, j) * W;
            localparam int c_OUT_LSB = tree_offset(N, j + 1) * W;

            mux2_stage #(
                .W       (W),
                .COUNT   (c_CNT),
                .TAG_W   (L),
                .SEL_BIT (j)
            ) u_stage (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_adv),
                .i_valid (w_valid[j]),
                .i_tag   (w_tag[j]),
                .i_data  (w_tree[c_IN_LSB +: 2*c_CNT*W]),
                .o_valid (w_valid[j+1]),
                .o_tag   (w_tag[j+1]),
                .o_data  (w_tree[c_OUT_LSB +: c_CNT*W])
            );
        end
    endgenerate

    assign out_data  = w_tree[(c_TOTAL-1)*W +: W];
    assign out_chan  = w_tag[L];
    assign out_valid = w_valid[L];

endmodule : mux_tree_pipe
`default_nettype wire

// File: tb/tb_mux_tree_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_tree_pipe
// Description : Self-checking bench: directed vector table, hand sequences for
//               reset/scan corners, and randomized traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_tree_pipe;

    localparam int W = 8;
    localparam int N = 8;
    localparam int L = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N*W-1:0] in_data = '0;
    logic [L-1:0]   sel = '0;
    logic           scan_en = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic [L-1:0]   out_chan;
    logic           out_valid;
    logic           out_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mux_tree_pipe #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .sel       (sel),
        .scan_en   (scan_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_chan  (out_chan),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    typedef struct {
        logic       rst;
        logic       vld;
        logic [2:0] sel;
        logic       rdy;
        logic       chk;
        logic       exp_ir;
        logic       exp_ov;
        logic [7:0] exp_d;
        logic [2:0] exp_c;
    } vec_t;

    typedef struct {
        logic       v;
        logic [2:0] c;
        logic [7:0] d;
    } slot_t;

    vec_t  tbl[19];
    slot_t pipe[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic std_data();
        for (int k = 0; k < N; k++) in_data[k*W +: W] = 8'h10 + 8'(k);
    endtask

    // Drive one cycle's inputs on the falling edge; outputs settle by #1.
    task automatic step(input logic r, input logic v, input logic [2:0] s,
                        input logic se, input logic rd);
        @(negedge clk);
        rst = r; in_valid = v; sel = s; scan_en = se; out_ready = rd;
        #1;
    endtask

    function automatic logic [2:0] exp_scan_chan(input int beat, input logic [2:0] s);
`ifdef MUX_TREE_PIPE_SCAN_EN
        return 3'(beat % N);
`else
        return s;
`endif
    endfunction

    initial begin
        logic [2:0] ec;
        logic       m_en;
        logic       m_scan;
        logic [2:0] m_cnt;
        logic [2:0] ch;
        slot_t      s;

        std_data();
        //            rst vld sel rdy chk ir ov  data   chan
        tbl[0]  = '{1'b1,1'b0,3'd0,1'b1,1'b0,1'b1,1'b0,8'h00,3'd0};
        tbl[1]  = '{1'b1,1'b1,3'd3,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[2]  = '{1'b0,1'b1,3'd5,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[3]  = '{1'b0,1'b0,3'd6,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[4]  = '{1'b0,1'b0,3'd6,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[5]  = '{1'b0,1'b0,3'd6,1'b1,1'b1,1'b1,1'b1,8'h15,3'd5};
        tbl[6]  = '{1'b0,1'b1,3'd1,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[7]  = '{1'b0,1'b0,3'd6,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[8]  = '{1'b0,1'b0,3'd6,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[9]  = '{1'b0,1'b0,3'd6,1'b1,1'b1,1'b1,1'b1,8'h11,3'd1};
        tbl[10] = '{1'b0,1'b1,3'd2,1'b0,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[11] = '{1'b0,1'b0,3'd2,1'b0,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[12] = '{1'b0,1'b0,3'd2,1'b0,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[13] = '{1'b0,1'b0,3'd2,1'b0,1'b1,1'b0,1'b1,8'h12,3'd2};
        tbl[14] = '{1'b0,1'b1,3'd7,1'b0,1'b1,1'b0,1'b1,8'h12,3'd2};
        tbl[15] = '{1'b0,1'b0,3'd7,1'b1,1'b1,1'b1,1'b1,8'h12,3'd2};
        tbl[16] = '{1'b0,1'b0,3'd7,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[17] = '{1'b0,1'b0,3'd7,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};
        tbl[18] = '{1'b0,1'b0,3'd7,1'b1,1'b1,1'b1,1'b0,8'h00,3'd0};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].sel, 1'b0, tbl[i].rdy);
            if (tbl[i].chk) begin
                check($sformatf("tbl%0d in_ready", i), 32'(in_ready), 32'(tbl[i].exp_ir));
                check($sformatf("tbl%0d out_valid", i), 32'(out_valid), 32'(tbl[i].exp_ov));
                // Row 1 follows a reset edge, so data/chan must read zero.
                if (tbl[i].exp_ov || i == 1) begin
                    check($sformatf("tbl%0d out_data", i), 32'(out_data), 32'(tbl[i].exp_d));
                    check($sformatf("tbl%0d out_chan", i), 32'(out_chan), 32'(tbl[i].exp_c));
                end
            end
        end

        // Reset with three scan beats in flight: none may surface afterwards.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 3'd4, 1'b1, 1'b1);
        step(1'b1, 1'b0, 3'd4, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
            check($sformatf("rstflight%0d out_valid", i), 32'(out_valid), 32'd0);
            if (i == 0) check("rstflight in_ready", 32'(in_ready), 32'd1);
        end
        step(1'b0, 1'b1, 3'd4, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        step(1'b0, 1'b0, 3'd4, 1'b1, 1'b1);
        ec = exp_scan_chan(0, 3'd4);
        check("scanrestart out_valid", 32'(out_valid), 32'd1);
        check("scanrestart out_chan", 32'(out_chan), 32'(ec));
        check("scanrestart out_data", 32'(out_data), 32'(8'h10 + 8'(ec)));

        // Ten back-to-back beats with scan_en=1, sel=2.
        step(1'b1, 1'b0, 3'd2, 1'b1, 1'b1);
        for (int st = 0; st < 14; st++) begin
            step(1'b0, st < 10, 3'd2, 1'b1, 1'b1);
            if (st >= 3 && st < 13) begin
                ec = exp_scan_chan(st - 3, 3'd2);
                check($sformatf("burst%0d out_valid", st - 3), 32'(out_valid), 32'd1);
                check($sformatf("burst%0d out_chan", st - 3), 32'(out_chan), 32'(ec));
                check($sformatf("burst%0d out_data", st - 3), 32'(out_data), 32'(8'h10 + 8'(ec)));
            end else if (st == 13) begin
                check("burst tail out_valid", 32'(out_valid), 32'd0);
            end
        end

        // Randomized traffic against an in-bench queue model of the pipe.
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);
        pipe = {};
        for (int i = 0; i < L; i++) pipe.push_back('{1'b0, 3'd0, 8'h00});
        m_cnt = 3'd0;
        @(posedge clk);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            sel       = 3'($urandom_range(0, N - 1));
            scan_en   = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom};
            #1;
            m_en = out_ready | ~pipe[0].v;
            check("rand in_ready", 32'(in_ready), 32'(m_en));
            check("rand out_valid", 32'(out_valid), 32'(pipe[0].v));
            if (pipe[0].v) begin
                check("rand out_chan", 32'(out_chan), 32'(pipe[0].c));
                check("rand out_data", 32'(out_data), 32'(pipe[0].d));
            end
            @(posedge clk);
`ifdef MUX_TREE_PIPE_SCAN_EN
            m_scan = scan_en;
`else
            m_scan = 1'b0;
`endif
            if (rst) begin
                foreach (pipe[i]) pipe[i] = '{1'b0, 3'd0, 8'h00};
                m_cnt = 3'd0;
            end else if (m_en) begin
                ch  = m_scan ? m_cnt : sel;
                s.v = in_valid;
                s.c = ch;
                s.d = in_data[int'(ch)*W +: W];
                void'(pipe.pop_front());
                pipe.push_back(s);
                if (in_valid && m_scan) m_cnt = m_cnt + 3'd1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mux_tree_pipe
`default_nettype wire

// File: doc/mux_tree_pipe.md
MUX_TREE_PIPE -- requirements
Module: mux_tree_pipe

Interface
REQ-001 Parameter W, default 8, data width per channel in bits (>=1).
REQ-002 Parameter N, default 8, channel count, power of two, 2..64.
REQ-003 Derived L = log2(N): tree depth, pipeline latency and select width.
REQ-004 clk  input  1  sole clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_data  input  N*W  flat channel bus, channel k at bits [k*W +: W].
REQ-007 sel  input  L  channel select for manual mode.
REQ-008 scan_en  input  1  1 = auto-scan mode, 0 = manual mode.
REQ-009 in_valid  input  1  source offers a beat this cycle.
REQ-010 in_ready  output  1  block accepts a beat this cycle.
REQ-011 out_data  output  W  selected channel data.
REQ-012 out_chan  output  L  channel index that produced out_data.
REQ-013 out_valid  output  1  out_data/out_chan are valid.
REQ-014 out_ready  input  1  sink accepts the output beat.

Function
REQ-015 The block SHALL be a binary tree of L registered 2:1 mux levels, one pipeline register per level; level j is steered by bit j of the beat's channel index, LSB at the input level.
REQ-016 A global advance enable SHALL equal out_ready OR NOT out_valid; every level register, its valid bit and its channel tag SHALL load only when the enable is 1.
REQ-017 in_ready SHALL equal the advance enable, combinationally, with no dependence on in_valid.
REQ-018 A beat is accepted when in_valid AND in_ready; it SHALL appear at the output exactly L advancing cycles later with out_chan equal to its channel index.
REQ-019 Bubbles (in_valid=0 while enabled) SHALL propagate as invalid slots; there is no bubble compression.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_chan and out_valid SHALL hold stable and no beat is lost or duplicated.
REQ-021 Channel index SHALL be sampled only at acceptance: manual mode uses sel; scan mode uses the scan counter; later changes to sel, scan_en or in_data do not affect in-flight beats.
REQ-022 Scan counter (L bits) SHALL increment by 1 on each accepted beat in scan mode and wrap from N-1 to 0; it holds otherwise, including in manual mode.
REQ-023 Switching scan_en 0->1 SHALL resume from the held counter value, not from 0.
REQ-024 Full-throughput: with out_ready=1 continuously, one beat per cycle SHALL be accepted and delivered.

Reset
REQ-025 While rst=1 at a clock edge: all valid bits, out_valid, out_data, out_chan and the scan counter SHALL become 0; in_ready is 1 on the following cycle.
REQ-026 Reset mid-operation SHALL discard all in-flight beats; none reappear after rst deasserts.
REQ-027 A beat presented in the cycle rst is high SHALL NOT be accepted.

Configuration
REQ-028 Macro MUX_TREE_PIPE_SCAN_EN: when defined, the scan counter and scan mode SHALL be implemented as REQ-021..023.
REQ-029 When undefined, the scan_en port SHALL remain present but be ignored, no scan counter SHALL be built, and every beat uses sel.

Structure
REQ-030 Shared package mux_tree_pkg SHALL hold the log2 helper function, default W/N constants and the mode enum (MODE_MANUAL, MODE_SCAN).
REQ-031 One sub-module mux2_stage SHALL implement one registered tree level (width-parametrised, with valid and channel-tag pass-through), instantiated L times via generate.

Verification (W=8, N=8, L=3, channel k data = 0x10+k unless stated)
REQ-032 Manual: sel=5, one beat, out_ready=1 -> 3 cycles later out_data=0x15, out_chan=5, out_valid=1 for one cycle.
REQ-033 Scan (macro defined): scan_en=1, 10 back-to-back beats -> out_chan sequence 0..7,0,1, out_data 0x10..0x17,0x10,0x11, one per cycle.
REQ-034 Backpressure: stream of beats, out_ready=0 for 4 cycles -> in_ready=0 and outputs held for those 4 cycles; full sequence later delivered in order without loss or duplication.
REQ-035 Reset mid-flight: 3 beats in flight, rst=1 for one cycle -> out_valid=0 for next 3 cycles, scan restarts at chan 0.
REQ-036 Macro undefined: scan_en=1, sel=2, 4 beats -> all outputs out_chan=2, out_data=0x12.
REQ-037 Select change in flight: accept beat with sel=1, then set sel=6 next cycle -> first output out_chan=1, out_data=0x11.
